// File: rtl/sdram_pkg.sv
// Constants and FSM encoding shared by the SDRAM write-side buffer and write engine.
package sdram_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 10;
    localparam int BURST_LEN   = 8;
    localparam int WRITE_TIMES = 32;
    localparam int TRIG_LEVEL  = BURST_LEN * WRITE_TIMES;
    localparam int POP_CNT_W   = 9;

    // One-hot so each state bit can be probed directly.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_TRIG = 3'b010,
        ST_BUSY = 3'b100
    } wr_state_t;

endpackage

// File: rtl/sdram_wr_buffer_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module sdram_wr_buffer_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_wr_buffer.sv
// FWFT staging FIFO ahead of the SDRAM write engine; pulses write_trig once a
// full transaction is buffered and then tracks the engine's pops.
module sdram_wr_buffer
    import sdram_pkg::*;
#(
    parameter int DATA_W     = sdram_pkg::DATA_W,
    parameter int ADDR_W     = sdram_pkg::ADDR_W,
    parameter int TRIG_LEVEL = sdram_pkg::TRIG_LEVEL
) (
    input  logic              sysclk_100M,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_vld,
    input  logic              frame_flush,
    output logic              write_trig,
    input  logic              data_vld,
    output logic [DATA_W-1:0] sdram_wdata,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              underflow,
    output wr_state_t         fsm_state
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [POP_CNT_W-1:0] pop_cnt;
    logic [DATA_W-1:0]    ram_rdata;
    logic                 empty, full, push_ok, pop_ok, last_pop;
    wr_state_t            state, state_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // A pop at full frees the slot the push lands in, so the push is still taken.
    assign pop_ok   = data_vld && !empty && !frame_flush;
    assign push_ok  = pix_vld && (!full || pop_ok) && !frame_flush;
    assign last_pop = pop_ok && (pop_cnt == POP_CNT_W'(TRIG_LEVEL - 1));

    sdram_wr_buffer_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sysclk_100M),
        .we    (push_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (pix_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign sdram_wdata = empty ? '0 : ram_rdata;
    assign fifo_level  = wr_ptr - rd_ptr;
    assign write_trig  = (state == ST_TRIG);
    assign fsm_state   = state;

    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (frame_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (pix_vld && !push_ok) overflow  <= 1'b1;
            if (data_vld && empty)   underflow <= 1'b1;
        end
    end

    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (frame_flush || state == ST_TRIG || last_pop) begin
                pop_cnt <= '0;
            end else if (state == ST_BUSY && pop_ok) begin
                pop_cnt <= pop_cnt + POP_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (fifo_level >= PTR_W'(TRIG_LEVEL)) state_nxt = ST_TRIG;
                ST_TRIG: state_nxt = ST_BUSY;
                ST_BUSY: if (last_pop) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Directed bench for sdram_wr_buffer with a queue model of FIFO contents and sticky flags.
module tb_sdram_wr_buffer;
    import sdram_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pix_data = '0;
    logic        pix_vld = 1'b0;
    logic        frame_flush = 1'b0;
    logic        data_vld = 1'b0;
    logic        write_trig;
    logic [15:0] sdram_wdata;
    logic [10:0] fifo_level;
    logic        overflow, underflow;
    wr_state_t   fsm_state;

    int          errors = 0;
    int          checks = 0;
    int          trig_cnt = 0;
    int          t0;
    logic [15:0] exp_q[$];
    bit          exp_ovf = 0;
    bit          exp_unf = 0;

    sdram_wr_buffer dut (
        .sysclk_100M (clk),
        .rst         (rst),
        .pix_data    (pix_data),
        .pix_vld     (pix_vld),
        .frame_flush (frame_flush),
        .write_trig  (write_trig),
        .data_vld    (data_vld),
        .sdram_wdata (sdram_wdata),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underflow   (underflow),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (write_trig) trig_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with optional push/pop; the model decides acceptance independently.
    task automatic cycle(input bit push_en, input logic [15:0] d, input bit pop_en);
        bit pop_ok, push_ok;
        pop_ok  = pop_en && (exp_q.size() > 0);
        push_ok = push_en && ((exp_q.size() < DEPTH) || pop_ok);
        if (pop_ok) check("rd_data", 32'(sdram_wdata), 32'(exp_q[0]));
        pix_vld  = push_en;
        pix_data = d;
        data_vld = pop_en;
        step();
        pix_vld  = 1'b0;
        data_vld = 1'b0;
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(d);
        if (push_en && !push_ok) exp_ovf = 1;
        if (pop_en && !pop_ok) exp_unf = 1;
    endtask

    task automatic flush_cycle();
        frame_flush = 1'b1;
        pix_vld     = 1'b1;
        pix_data    = 16'hdead;
        data_vld    = 1'b1;
        step();
        frame_flush = 1'b0;
        pix_vld     = 1'b0;
        data_vld    = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        repeat (3) step();
        check("rst_trig", 32'(write_trig), 0);
        check("rst_wdata", 32'(sdram_wdata), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();

        // Ramp fill: no trigger until the 256th word lands.
        for (int i = 0; i < 255; i++) cycle(1, 16'(i), 0);
        check("lvl_255", 32'(fifo_level), 255);
        check("no_trig_255", 32'(trig_cnt), 0);
        cycle(1, 16'd255, 0);
        check("lvl_256", 32'(fifo_level), 256);
        check("trig_not_yet", 32'(write_trig), 0);
        cycle(0, 0, 0);
        check("trig_high", 32'(write_trig), 1);
        cycle(0, 0, 0);
        check("trig_low", 32'(write_trig), 0);
        check("state_busy", 32'(fsm_state), 32'(ST_BUSY));
        check("one_trig", 32'(trig_cnt), 1);

        // Drain the ramp in order.
        for (int i = 0; i < 256; i++) begin
            check("ramp_val", 32'(sdram_wdata), i);
            cycle(0, 0, 1);
        end
        check("drain_state", 32'(fsm_state), 32'(ST_IDLE));
        check("drain_level", 32'(fifo_level), 0);
        repeat (2) cycle(0, 0, 0);
        check("drain_trig", 32'(trig_cnt), 1);

        // Fill to full, then simultaneous push/pop across the address wrap.
        for (int i = 0; i < DEPTH; i++) cycle(1, 16'h4000 + 16'(i), 0);
        check("full_level", 32'(fifo_level), 1024);
        check("full_no_ovf", 32'(overflow), 0);
        check("full_head", 32'(sdram_wdata), 32'h4000);
        for (int k = 0; k < 10; k++) cycle(1, 16'h8000 + 16'(k), 1);
        check("pp_level", 32'(fifo_level), 1024);
        check("pp_no_ovf", 32'(overflow), 32'(exp_ovf));
        cycle(1, 16'h9999, 0);
        check("ovf_level", 32'(fifo_level), 1024);
        check("ovf_set", 32'(overflow), 32'(exp_ovf));
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1);
        check("full_drain_level", 32'(fifo_level), 0);
        check("model_empty", 32'(exp_q.size()), 0);
        check("no_unf_yet", 32'(underflow), 32'(exp_unf));

        // Pop while empty.
        cycle(0, 0, 1);
        check("unf_set", 32'(underflow), 32'(exp_unf));
        check("unf_wdata", 32'(sdram_wdata), 0);
        check("unf_level", 32'(fifo_level), 0);
        cycle(1, 16'h1234, 0);
        check("fwft_word", 32'(sdram_wdata), 32'h1234);
        check("fwft_level", 32'(fifo_level), 1);

        // Flush with a concurrent push and pop; sticky flags survive.
        flush_cycle();
        check("fl_level", 32'(fifo_level), 0);
        check("fl_state", 32'(fsm_state), 32'(ST_IDLE));
        check("fl_wdata", 32'(sdram_wdata), 0);
        check("fl_ovf_sticky", 32'(overflow), 1);
        check("fl_unf_sticky", 32'(underflow), 1);

        // Flush in the middle of a transaction.
        t0 = trig_cnt;
        for (int i = 0; i < 256; i++) cycle(1, 16'h2000 + 16'(i), 0);
        repeat (3) cycle(0, 0, 0);
        check("tx2_trig", 32'(trig_cnt - t0), 1);
        for (int i = 0; i < 100; i++) cycle(0, 0, 1);
        check("mid_state", 32'(fsm_state), 32'(ST_BUSY));
        check("mid_level", 32'(fifo_level), 156);
        flush_cycle();
        check("mid_fl_level", 32'(fifo_level), 0);
        check("mid_fl_state", 32'(fsm_state), 32'(ST_IDLE));
        t0 = trig_cnt;
        for (int i = 0; i < 256; i++) cycle(1, 16'h3000 + 16'(i), 0);
        repeat (4) cycle(0, 0, 0);
        check("refill_trig", 32'(trig_cnt - t0), 1);
        check("refill_head", 32'(sdram_wdata), 32'h3000);
        check("refill_state", 32'(fsm_state), 32'(ST_BUSY));

        // Reset mid-transaction clears everything including sticky flags.
        rst = 1'b1;
        #2;
        check("arst_level", 32'(fifo_level), 0);
        step();
        check("arst_ovf", 32'(overflow), 0);
        check("arst_unf", 32'(underflow), 0);
        check("arst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("arst_wdata", 32'(sdram_wdata), 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_wr_buffer.md
# sdram_wr_buffer

Single-clock write-side staging buffer that sits directly upstream of the SDRAM write engine. It accepts the 16-bit pixel stream already in the 100 MHz domain and stores it in a first-word-fall-through FIFO. Once one full write transaction of data is buffered, it issues a one-cycle `write_trig`. It then presents one data word per `data_vld` beat on the SDRAM write-data bus.

## Interface
- `DATA_W`, 16, pixel/SDRAM word width
- `ADDR_W`, 10, FIFO address width; depth = 2^ADDR_W = 1024 words
- `TRIG_LEVEL`, 256, words per write transaction (32 bursts × 8); must be ≤ 2^ADDR_W
- `sysclk_100M`  in  1  system clock; one clock, all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pix_data`  in  DATA_W  incoming pixel word
- `pix_vld`  in  1  push strobe for `pix_data`
- `frame_flush`  in  1  single-cycle pulse at frame start; discards all buffered data
- `write_trig`  out  1  single-cycle request to the write engine to start one transaction
- `data_vld`  in  1  write engine consumes `sdram_wdata` this cycle
- `sdram_wdata`  out  DATA_W  current FIFO head word (FWFT)
- `fifo_level`  out  ADDR_W+1  number of words stored
- `overflow`  out  1  sticky; a push was dropped while the FIFO was full
- `underflow`  out  1  sticky; `data_vld` arrived while the FIFO was empty

## Operation
- Storage: circular RAM with `ADDR_W+1`-bit write and read pointers. The MSB distinguishes full from empty.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
  - `fifo_level` = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- Push: `pix_vld` && !full writes `mem[wr_ptr]` and increments wr_ptr. `pix_vld` && full drops the word and sets `overflow`.
- Pop: `data_vld` && !empty increments rd_ptr. `data_vld` && empty leaves the pointer unchanged and sets `underflow`.
- Push and pop in the same cycle are both honoured.
  - At full, the push is accepted only because the pop frees a slot in that same cycle; no overflow.
  - At empty, the pop is an underflow; the pushed word is stored.
- FWFT: `sdram_wdata` always shows `mem[rd_ptr]`. When the FIFO is empty it shows 0.
- Control FSM, states IDLE, TRIG, BUSY:
  - IDLE → TRIG when `fifo_level` ≥ `TRIG_LEVEL`.
  - TRIG asserts `write_trig` for exactly one cycle, then goes unconditionally to BUSY. The pop counter is cleared on entry to BUSY.
  - BUSY counts accepted pops (9-bit counter). When the count reaches `TRIG_LEVEL` the FSM returns to IDLE and the counter clears.
  - No new `write_trig` is issued while in TRIG or BUSY.
- `frame_flush` is honoured in any state. It clears both pointers and the pop counter and forces IDLE. It does not clear the sticky flags.
  - Any push or pop in the same cycle as the flush is ignored.
- The sticky flags clear only on `rst`.

## Timing
- Reset values: `write_trig` 0, `sdram_wdata` 0, `fifo_level` 0, `overflow` 0, `underflow` 0. FSM resets to IDLE.
- Reset asserted mid-transaction aborts it immediately; buffered data is lost.
- Push → visible in `fifo_level` the next cycle. Push into an empty FIFO → on `sdram_wdata` the next cycle.
- Pop: `sdram_wdata` advances to the next word the cycle after a `data_vld` beat. The write engine must sample the word in the same cycle it asserts `data_vld`.
- Trigger latency: `fifo_level` reaching `TRIG_LEVEL` at cycle N → `write_trig` high at cycle N+1.
- Back-to-back transactions: once BUSY exits to IDLE, a level still ≥ `TRIG_LEVEL` triggers again one cycle later.
- Pointer wrap at 2^(ADDR_W+1) is seamless.

## Structure
- Shared package `sdram_pkg`: FSM state encodings (one-hot), `DATA_W`, `TRIG_LEVEL` defaults, burst length 8, and write-times 32. The write engine consumes the same constants.
- One sub-module: `sdram_wr_buffer_ram`, a simple dual-port RAM with synchronous write and asynchronous read, no reset.
- Pointers, flags, level, and FSM live in the top level.

## Test plan
- Reset then push 255 words → `write_trig` stays 0. Push the 256th word → `write_trig` is a single pulse one cycle later and `fifo_level`=256.
- Push the ramp 0..255, then assert `data_vld` for 256 cycles → `sdram_wdata` reads 0..255 in order. The FSM returns to IDLE after the 256th pop and `fifo_level`=0.
- Push 1025 words with no pops → `fifo_level`=1024 and `overflow`=1. Words 0..1023 are retained; word 1024 is dropped.
- From full, push and pop in the same cycle for 10 cycles → `fifo_level` holds 1024 and no overflow occurs. Data ordering is preserved across the pointer wrap.
- `data_vld` with the FIFO empty → `underflow`=1, `sdram_wdata`=0, and the pointers are unchanged.
- Pulse `frame_flush` mid-BUSY after 100 pops → `fifo_level`=0 and FSM in IDLE the next cycle. A new 256-word fill produces exactly one `write_trig`.
